// File: rtl/bidir_port_bank.sv
`default_nettype none
// ============================================================================
//  Module   : bidir_port_bank
//  Purpose  : N-channel bidirectional blink/listen port with guarded turnaround
//             and saturating per-channel edge counters.
//  Revision : 1.0 - initial release
// ============================================================================
module bidir_port_bank #(
    parameter int CHANNELS    = 2,
    parameter int DIV_BITS    = 23,
    parameter int TURN_CYCLES = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                      clk48,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       dir_req,
    input  logic [CHANNELS-1:0]       pad_i,
    input  logic                      cnt_clr,
    output logic [CHANNELS-1:0]       pad_o,
    output logic [CHANNELS-1:0]       pad_oe,
    output logic [CHANNELS-1:0]       in_val,
    output logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS*CNT_W-1:0] edge_cnt
);

    localparam int                TW          = $clog2(TURN_CYCLES + 1);
    localparam logic [TW-1:0]     c_turn_load = TW'(TURN_CYCLES);
    localparam logic [TW-1:0]     c_timer_one = TW'(1);
    localparam logic [DIV_BITS:0] c_ctr_one   = (DIV_BITS+1)'(1);
    localparam logic [CNT_W-1:0]  c_cnt_sat   = '1;
    localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);

    typedef enum logic [1:0] {
        LISTEN      = 2'd0,
        TURN_TO_OUT = 2'd1,
        DRIVE       = 2'd2,
        TURN_TO_IN  = 2'd3
    } state_t;

    logic [DIV_BITS:0]    counter_q;
    logic [CHANNELS-1:0]  dir_sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0]  in_sync_q  [SYNC_STAGES];
    logic [CHANNELS-1:0]  dir_s;

    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_q + c_ctr_one;
        end
    end

    // Direction flops reset high so an unconfigured pad comes up Hi-Z.
    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                dir_sync_q[i] <= '1;
                in_sync_q[i]  <= '0;
            end
        end else begin
            dir_sync_q[0] <= dir_req;
            in_sync_q[0]  <= pad_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                dir_sync_q[i] <= dir_sync_q[i-1];
                in_sync_q[i]  <= in_sync_q[i-1];
            end
        end
    end

    assign dir_s  = dir_sync_q[SYNC_STAGES-1];
    assign in_val = in_sync_q[SYNC_STAGES-1];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        localparam logic c_phase = ((k % 2) == 1);

        state_t           state_q, state_d;
        logic [TW-1:0]    timer_q, timer_d;
        logic             pad_o_q, pad_oe_q, in_valid_q, busy_q;
        logic             prev_q, prev_vld_q;
        logic [CNT_W-1:0] cnt_q;

        always_comb begin
            state_d = state_q;
            timer_d = timer_q;
            case (state_q)
                LISTEN: begin
                    if (!dir_s[k]) begin
                        state_d = TURN_TO_OUT;
                        timer_d = c_turn_load;
                    end
                end
                TURN_TO_OUT: begin
                    if (timer_q <= c_timer_one) state_d = DRIVE;
                    else                        timer_d = timer_q - c_timer_one;
                end
                DRIVE: begin
                    if (dir_s[k]) begin
                        state_d = TURN_TO_IN;
                        timer_d = c_turn_load;
                    end
                end
                TURN_TO_IN: begin
                    if (timer_q <= c_timer_one) state_d = LISTEN;
                    else                        timer_d = timer_q - c_timer_one;
                end
                default: state_d = LISTEN;
            endcase
        end

        // Outputs are decoded from the next state so they switch on the transition edge.
        always_ff @(posedge clk48) begin
            if (!rst_n) begin
                state_q    <= LISTEN;
                timer_q    <= '0;
                pad_o_q    <= 1'b0;
                pad_oe_q   <= 1'b0;
                in_valid_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                state_q    <= state_d;
                timer_q    <= timer_d;
                pad_o_q    <= ~counter_q[DIV_BITS] ^ c_phase;
                pad_oe_q   <= (state_d == DRIVE);
                in_valid_q <= (state_d == LISTEN);
                busy_q     <= (state_d == TURN_TO_OUT) || (state_d == TURN_TO_IN);
            end
        end

        // prev is reloaded on LISTEN entry so a change seen while driving is not counted.
        always_ff @(posedge clk48) begin
            if (!rst_n) begin
                prev_q     <= 1'b0;
                prev_vld_q <= 1'b0;
                cnt_q      <= '0;
            end else begin
                if (state_q == LISTEN) begin
                    prev_q     <= in_val[k];
                    prev_vld_q <= 1'b1;
                end else begin
                    prev_vld_q <= 1'b0;
                end
                if (cnt_clr) begin
                    cnt_q <= '0;
                end else if ((state_q == LISTEN) && prev_vld_q &&
                             (in_val[k] != prev_q) && (cnt_q != c_cnt_sat)) begin
                    cnt_q <= cnt_q + c_cnt_one;
                end
            end
        end

        assign pad_o[k]                   = pad_o_q;
        assign pad_oe[k]                  = pad_oe_q;
        assign in_valid[k]                = in_valid_q;
        assign busy[k]                    = busy_q;
        assign edge_cnt[k*CNT_W +: CNT_W] = cnt_q;
    end

endmodule
`default_nettype wire

// File: doc/bidir_port_bank.md
Name: bidir_port_bank

Overview:
- N-channel successor to the single-pin Hi-Z test port.
- Each channel drives a blink pattern or listens, selected per channel at run time.
- Direction changes go through a guarded turnaround so the pad is never driven while the direction flips.
- Inputs pass through a synchroniser and feed per-channel edge counters; the tri-state pad primitive sits outside this block and connects to pad_o, pad_oe and pad_i.

Parameters:
CHANNELS, 2, number of independent bidirectional channels
DIV_BITS, 23, index of the free-running counter bit used as the blink pattern
TURN_CYCLES, 4, turnaround length in cycles (>=1)
SYNC_STAGES, 2, flop stages on dir_req and pad_i (>=2)
CNT_W, 8, width of each saturating edge counter

Ports:
clk48  in  1  system clock, single clock domain
rst_n  in  1  synchronous reset, active-low
dir_req  in  CHANNELS  per-channel direction request, asynchronous; 1 = input/Hi-Z, 0 = drive
pad_i  in  CHANNELS  pad readback from the IO primitive, asynchronous
cnt_clr  in  1  synchronous clear of all edge counters
pad_o  out  CHANNELS  registered output data to the IO primitive
pad_oe  out  CHANNELS  registered output enable; 1 = drive
in_val  out  CHANNELS  synchronised pad_i
in_valid  out  CHANNELS  1 while the channel is in LISTEN
busy  out  CHANNELS  1 while the channel is in either turnaround state
edge_cnt  out  CHANNELS*CNT_W  per-channel edge count; channel k occupies bits [k*CNT_W +: CNT_W]

Behaviour:
- Reset (rst_n low at a clk48 edge):
  - counter=0, every channel in LISTEN.
  - pad_oe=0, pad_o=0, in_val=0, in_valid=0, busy=0, edge_cnt=0.
  - dir_req synchroniser flops reset to 1 (safe Hi-Z); pad_i synchroniser flops reset to 0.
  - Reset mid-operation takes effect at that edge: pad_oe drops immediately and turnaround timers are discarded.
- Counter:
  - Free-running, DIV_BITS+1 bits, wraps modulo 2^(DIV_BITS+1).
  - pattern_k = ~counter[DIV_BITS] XOR k[0], so adjacent channels run in antiphase.
  - pad_o[k] is registered from pattern_k every cycle, independent of state.
- Synchronisers: dir_s[k] and in_val[k] are dir_req and pad_i delayed by SYNC_STAGES flops.
- Per-channel FSM, states LISTEN, TURN_TO_OUT, DRIVE, TURN_TO_IN:
  - LISTEN: pad_oe=0, in_valid=1. If dir_s=0, go to TURN_TO_OUT and load the timer with TURN_CYCLES.
  - TURN_TO_OUT: pad_oe=0, busy=1, timer decrements each cycle. Go to DRIVE when the timer expires; pad_oe=1 is registered on the same edge.
  - DRIVE: pad_oe=1. If dir_s=1, go to TURN_TO_IN; pad_oe=0 is registered on that edge.
  - TURN_TO_IN: pad_oe=0, busy=1. After TURN_CYCLES cycles go to LISTEN.
  - Turnarounds are never aborted. dir_s is re-evaluated only in LISTEN/DRIVE, so a request reversal during a turn causes a full return trip afterwards.
- Latency with SYNC_STAGES=2, counting rising edges after dir_req changes:
  - DRIVE->input: pad_oe falls at edge 3; in_valid rises at edge 3+TURN_CYCLES.
  - LISTEN->output: in_valid falls at edge 3; pad_oe rises at edge 3+TURN_CYCLES.
- Edge counter, active only in LISTEN:
  - On the first LISTEN cycle, load prev=in_val without counting.
  - Afterwards, each cycle in_val != prev increments edge_cnt[k], saturating at 2^CNT_W-1, with no wrap.
  - Outside LISTEN the counter holds.
  - cnt_clr zeroes all counters and wins over a simultaneous edge (result 0).
- Channels are fully independent; simultaneous direction changes on multiple channels are all honoured in the same cycle.

Test Plan:
Bench parameters: CHANNELS=2, DIV_BITS=3, TURN_CYCLES=4, CNT_W=3.
1. Reset: hold rst_n low 5 cycles with dir_req=2'b00 -> all outputs 0 during reset. After release, busy=1 from edge 3 and pad_oe=2'b11 at edge 7.
2. Pattern: both channels in DRIVE -> pad_o[0] toggles every 8 cycles, pad_o[1]==~pad_o[0] on every cycle, period 16 cycles across counter wrap.
3. Turnaround: ch0 in DRIVE, dir_req[0] 0->1 -> pad_oe[0]=0 at edge 3, busy[0]=1 edges 3-6, in_valid[0]=1 at edge 7. ch1 stays pad_oe=1 throughout.
4. Edge count: ch0 in LISTEN, toggle pad_i[0] 5 times, 4 cycles apart -> edge_cnt[0]=5. Continue to 12 toggles -> edge_cnt[0]=7 (saturated). No count on LISTEN entry even if pad_i differs from the stale prev.
5. Clear collision: assert cnt_clr on the same cycle in_val[0] changes -> edge_cnt[0]=0 next cycle. The next toggle gives 1.
6. Reversal during turn and reset:
   - dir_req[0]=1 pulse 3 cycles long from DRIVE -> full TURN_TO_IN, one LISTEN cycle, then TURN_TO_OUT; pad_oe never 1 while busy.
   - rst_n low while in DRIVE -> pad_oe=0 at that edge and state LISTEN.
